msg_serializer: RTL and testbench

MSG_SERIALIZER -- requirements
Module: msg_serializer

---
 rtl/msg_serializer_pkg.sv | 16 +
 rtl/msg_serializer.sv | 83 ++++++++
 tb/tb_msg_serializer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/msg_serializer_pkg.sv
// msg_serializer_pkg: state encodings and message-width helpers for msg_serializer
package msg_serializer_pkg;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_WAIT_TX  = 3'd3,
        S_DONE     = 3'd4
    } state_t;
    localparam int N_DEF = 8;
    localparam int NUM_BYTES_DEF = 16;
    localparam int MSG_W = N_DEF * NUM_BYTES_DEF;
    function automatic int msg_w(input int n, input int nb);
        return n * nb;
    endfunction
endpackage

// File: rtl/msg_serializer.sv
// msg_serializer: feeds a snapshotted message to a UART TX one character at a time
module msg_serializer
    import msg_serializer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int NUM_BYTES = NUM_BYTES_DEF,
    parameter bit STOP_ON_NUL = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [N*NUM_BYTES-1:0]         data,
    input  logic                           tx_busy,
    output logic                           tx_enable,
    output logic [N-1:0]                   tx_data,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_BYTES+1)-1:0] sent_count,
    output logic [2:0]                     state
);
    localparam int W = msg_w(N, NUM_BYTES);
    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t           r_state, w_next;
    logic [W-1:0]     r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     w_char;
    logic             w_nul, w_last, w_tx_done;

    // the character on offer is always the top of the shift register
    assign w_char    = r_shift[W-1 -: N];
    assign w_nul     = STOP_ON_NUL && (w_char == '0);
    assign w_last    = r_idx == LAST_IDX;
    assign w_tx_done = (r_state == S_WAIT_TX) && !tx_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:     w_next = start ? S_SEND : S_IDLE;
            S_SEND:     w_next = w_nul ? S_DONE : S_WAIT_ACK;
            S_WAIT_ACK: w_next = tx_busy ? S_WAIT_TX : S_WAIT_ACK;
            S_WAIT_TX:  w_next = tx_busy ? S_WAIT_TX : (w_last ? S_DONE : S_SEND);
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_enable = (r_state == S_SEND) && !w_nul;
        tx_data   = (r_state == S_IDLE) ? '0 : w_char;
        busy      = r_state != S_IDLE;
        done      = r_state == S_DONE;
    end

    assign sent_count = r_cnt;
    assign state      = r_state;

    // index stops at the last character; DONE follows instead of a wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_shift <= data;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (w_tx_done) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_last) begin
                r_idx   <= r_idx + 1'b1;
                r_shift <= r_shift << N;
            end
        end
    end
endmodule

// File: tb/tb_msg_serializer.sv
// tb_msg_serializer: scoreboard bench with a plain and a stop-on-NUL instance, NUM_BYTES=4
module tb_msg_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        st0, txb0, en0, bz0, dn0, st1, txb1, en1, bz1, dn1;
    logic [31:0] d0, d1;
    logic [7:0]  txd0, txd1;
    logic [2:0]  cnt0, cnt1, state0, state1;
    int dly0 = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {int inst; bit is_done; logic [7:0] val;} ev_t;
    ev_t exp_q[$];

    msg_serializer #(.N(8), .NUM_BYTES(4), .STOP_ON_NUL(1'b0)) u0 (
        .clk(clk), .reset(rst), .start(st0), .data(d0), .tx_busy(txb0),
        .tx_enable(en0), .tx_data(txd0), .busy(bz0), .done(dn0),
        .sent_count(cnt0), .state(state0));

    msg_serializer #(.N(8), .NUM_BYTES(4), .STOP_ON_NUL(1'b1)) u1 (
        .clk(clk), .reset(rst), .start(st1), .data(d1), .tx_busy(txb1),
        .tx_enable(en1), .tx_data(txd1), .busy(bz1), .done(dn1),
        .sent_count(cnt1), .state(state1));

    // TX models: optional ack delay, then busy for 3 cycles per enable
    initial begin
        txb0 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (en0) begin
                repeat (dly0) @(posedge clk);
                #1 txb0 = 1'b1;
                repeat (3) @(posedge clk);
                #1 txb0 = 1'b0;
            end
        end
    end

    initial begin
        txb1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (en1) begin
                #1 txb1 = 1'b1;
                repeat (3) @(posedge clk);
                #1 txb1 = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int inst, input bit d, input logic [7:0] v);
        ev_t e;
        e.inst = inst;
        e.is_done = d;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic push_msg(input int inst, input logic [31:0] msg, input int n);
        for (int i = 0; i < n; i++) push(inst, 1'b0, msg[31-8*i -: 8]);
        push(inst, 1'b1, 8'(n));
    endtask

    task automatic observe(input int inst, input bit d, input logic [7:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event inst%0d done=%0d: got %0h expected none", inst, d, v);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != inst || e.is_done != d || e.val !== v) begin
                errors++;
                $display("FAIL scoreboard: got inst%0d done=%0d val %0h expected inst%0d done=%0d val %0h",
                         inst, d, v, e.inst, e.is_done, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (en0) observe(0, 1'b0, txd0);
        if (dn0) observe(0, 1'b1, {5'd0, cnt0});
        if (en1) observe(1, 1'b0, txd1);
        if (dn1) observe(1, 1'b1, {5'd0, cnt1});
    end

    task automatic wait_done(input int inst, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = (inst == 0) ? dn0 : dn1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout inst%0d: got no done expected done within %0d cycles", inst, max);
        end
    endtask

    task automatic pulse0();
        @(negedge clk) st0 = 1'b1;
        @(negedge clk) st0 = 1'b0;
    endtask

    task automatic pulse1();
        @(negedge clk) st1 = 1'b1;
        @(negedge clk) st1 = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; st0 = 1'b0; st1 = 1'b0; d0 = '0; d1 = '0;
        @(negedge clk);
        check("rst_state", 32'(state0), 0);
        check("rst_enable", 32'(en0), 0);
        check("rst_data", 32'(txd0), 0);
        check("rst_busy", 32'(bz0), 0);
        check("rst_done", 32'(dn0), 0);
        check("rst_count", 32'(cnt0), 0);
        @(negedge clk) rst = 1'b0;

        // ABCD, with a restart attempt and new data mid-message
        d0 = "ABCD";
        push_msg(0, "ABCD", 4);
        pulse0();
        repeat (5) @(negedge clk);
        d0 = "WXYZ"; st0 = 1'b1;
        @(negedge clk) st0 = 1'b0;
        wait_done(0, 100);
        check("abcd_count", 32'(cnt0), 4);
        @(negedge clk);
        check("idle_state", 32'(state0), 0);
        check("idle_busy", 32'(bz0), 0);
        check("idle_data", 32'(txd0), 0);
        repeat (20) @(negedge clk);
        check("count_hold", 32'(cnt0), 4);

        // stop on NUL
        d1 = {8'h41, 8'h42, 8'h00, 8'h44};
        push_msg(1, d1, 2);
        pulse1();
        wait_done(1, 100);
        check("nul_count", 32'(cnt1), 2);
        repeat (3) @(negedge clk);
        d1 = {8'h00, 8'h42, 8'h43, 8'h44};
        push_msg(1, d1, 0);
        pulse1();
        check("nul0_send_state", 32'(state1), 1);
        check("nul0_no_enable", 32'(en1), 0);
        @(negedge clk);
        check("nul0_done", 32'(dn1), 1);
        check("nul0_count", 32'(cnt1), 0);

        // reset during WAIT_TX of character 2
        repeat (3) @(negedge clk);
        d0 = "ABCD";
        push(0, 1'b0, 8'h41); push(0, 1'b0, 8'h42); push(0, 1'b0, 8'h43);
        pulse0();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = (state0 == 3'd3) && (cnt0 == 3'd2);
        end
        check("reach_wait_tx2", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(state0), 0);
        check("arst_enable", 32'(en0), 0);
        check("arst_data", 32'(txd0), 0);
        check("arst_busy", 32'(bz0), 0);
        check("arst_done", 32'(dn0), 0);
        check("arst_count", 32'(cnt0), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        push_msg(0, "ABCD", 4);
        pulse0();
        wait_done(0, 100);
        check("after_rst_count", 32'(cnt0), 4);

        // delayed acknowledge
        dly0 = 5;
        repeat (3) @(negedge clk);
        push_msg(0, "ABCD", 4);
        pulse0();
        repeat (3) @(negedge clk);
        check("ack_wait_state", 32'(state0), 2);
        wait_done(0, 200);
        check("ack_count", 32'(cnt0), 4);
        dly0 = 0;

        // start held high: back-to-back messages
        repeat (3) @(negedge clk);
        push_msg(0, "ABCD", 4);
        push_msg(0, "ABCD", 4);
        @(negedge clk) st0 = 1'b1;
        wait_done(0, 100);
        @(negedge clk);
        check("gap_busy", 32'(bz0), 0);
        check("gap_state", 32'(state0), 0);
        @(negedge clk);
        check("gap_restart", 32'(state0), 1);
        wait_done(0, 100);
        st0 = 1'b0;
        repeat (30) @(negedge clk);
        check("final_idle", 32'(state0), 0);

        check("queue_left", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
